fetch_pc_sequencer: RTL and testbench
=====================================

Name: fetch_pc_sequencer

Overview:
- Owns the fetch program counter. Consumes the 28-bit jump field produced by the fetch jump-address shifter, plus register-jump and branch redirects from decode.
- Forms full 32-bit targets and sequences the PC, handling stalls, pending redirects, delay slot or flush, and misaligned targets.
- Sits between decode redirect logic and the instruction memory address port.

Parameters:
- RESET_PC, 32'h0040_0000, PC loaded on reset (text segment base)
- PC_WIDTH, 32, PC width; fixed at 32; other values are unsupported

Ports:
- Clk  input  1  single clock, rising edge
- Reset  input  1  synchronous reset, active-high
- Stall  input  1  hold the PC this cycle (downstream not ready)
- JumpValid  input  1  j/jal in decode this cycle
- Jump  input  28  jump field shifted left by 2 ({instr[25:0],2'b00})
- JumpRegValid  input  1  jr/jalr in decode this cycle
- RegTarget  input  32  register-sourced target
- BranchTaken  input  1  resolved taken branch in decode
- BranchOffset  input  32  sign-extended immediate, already shifted left by 2
- PC  output  32  current fetch address
- PCPlus4  output  32  PC + 4, modulo 2^32
- FetchValid  output  1  PC is a valid fetch this cycle
- Flush  output  1  squash the instruction fetched last cycle
- AddrError  output  1  one-cycle pulse on a misaligned redirect target

Behaviour:
- Reset (synchronous, active-high):
  - PC=RESET_PC; FetchValid=0; Flush=0; AddrError=0; pending register cleared; state INIT.
  - Reset overrides everything in any state, including PENDING and HALT.
- States:
  - INIT: one cycle, then RUN with FetchValid=1. Redirect inputs are ignored in INIT.
  - RUN: normal sequencing.
  - PENDING: a redirect has been latched during a stall.
  - HALT: entered on a misaligned target. FetchValid=0 and PC frozen until Reset.
- Decode PC (PC_D): internal register holding the PC fetched in the previous non-stalled cycle. All redirects belong to the instruction at PC_D.
- Target formation (all arithmetic mod 2^32):
  - Jump: {PC_D+4[31:28], Jump}
  - JumpReg: RegTarget
  - Branch: PC_D + 4 + BranchOffset
- Priority when several redirects are asserted in the same cycle: JumpRegValid > JumpValid > BranchTaken. Lower-priority requests are dropped.
- RUN, no stall, no redirect: PC <= PC+4 each cycle. The value wraps 32'hFFFF_FFFC -> 32'h0000_0000 silently.
- RUN, no stall, redirect: next PC = target (one-cycle redirect latency). Delay-slot versus flush handling is described under Optional Feature.
- RUN, Stall=1: PC and PC_D hold; FetchValid stays 1.
  - If a redirect arrives during the stall, latch its target and go to PENDING.
- PENDING:
  - Further redirects are ignored; the first latched redirect wins.
  - On the first cycle with Stall=0, PC <= latched target, return to RUN, clear the pending register.
- Misaligned target (target[1:0] != 0; possible only from JumpReg or Branch):
  - AddrError=1 for exactly one cycle; state HALT; FetchValid=0.
  - PC holds the last aligned value. No Flush is issued.
- Flush is a single-cycle pulse and is never asserted during INIT or HALT.

Optional Feature:
- Macro: FETCH_DELAY_SLOT_EN.
- Defined (MIPS delay-slot semantics):
  - The instruction at PC_D+4 (the current fetch) executes.
  - Redirect sets the next PC to the target; Flush is never asserted.
- Undefined:
  - Redirect asserts Flush=1 for one cycle, squashing the instruction fetched at PC_D+4; next PC = target.
  - A redirect applied from PENDING also asserts Flush on the apply cycle.

Test Plan:
- Reset then 3 free-running cycles, RESET_PC default -> cycle after INIT: PC=0x00400000, FetchValid=1; then 0x00400004, 0x00400008; Flush=0 and AddrError=0 throughout.
- PC_D=0x0040_0010, JumpValid=1, Jump=28'h0100_0040 -> next PC=0x0100_0040. Flush=0 with FETCH_DELAY_SLOT_EN, Flush=1 for one cycle without it.
- PC_D=0x0040_0020, BranchTaken=1, BranchOffset=0xFFFF_FFF0 -> next PC=0x0040_0014. Same cycle with JumpRegValid=1, RegTarget=0x0040_1000 -> next PC=0x0040_1000 (priority).
- Stall=1 for 3 cycles, JumpValid pulses in stall cycle 1 and BranchTaken in stall cycle 2 -> PC frozen; after Stall=0, PC equals the jump target only (first redirect wins).
- JumpRegValid=1, RegTarget=0x0040_0102 -> AddrError=1 for one cycle; FetchValid=0; PC holds; stays halted until Reset; Reset -> PC=0x00400000.
- Load PC=0xFFFF_FFF8 via JumpReg, run 2 cycles -> PC 0xFFFF_FFFC, then 0x0000_0000; PCPlus4=0x0000_0004.

Source files
------------

// File: rtl/fetch_pc_sequencer_if.sv
// Fetch PC sequencer bus: decode-side redirect requests in, fetch address out.
// master = decode/redirect side, slave = the PC sequencer itself.
interface fetch_pc_sequencer_if;
  logic        Stall;
  logic        JumpValid;
  logic [27:0] Jump;
  logic        JumpRegValid;
  logic [31:0] RegTarget;
  logic        BranchTaken;
  logic [31:0] BranchOffset;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic        FetchValid;
  logic        Flush;
  logic        AddrError;

  modport master (
    output Stall, JumpValid, Jump, JumpRegValid, RegTarget, BranchTaken, BranchOffset,
    input  PC, PCPlus4, FetchValid, Flush, AddrError
  );

  modport slave (
    input  Stall, JumpValid, Jump, JumpRegValid, RegTarget, BranchTaken, BranchOffset,
    output PC, PCPlus4, FetchValid, Flush, AddrError
  );
endinterface

// File: rtl/fetch_pc_sequencer.sv
// Fetch program counter sequencer.
// Forms jump / register-jump / branch targets relative to the decode PC,
// sequences the fetch PC through stalls and pending redirects, and halts on a
// misaligned redirect target.
// Build option FETCH_DELAY_SLOT_EN: when defined, the instruction after a
// redirecting instruction executes (delay slot) and Flush is never raised;
// when undefined, every applied redirect raises Flush for one cycle.
module fetch_pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000,
  parameter int          PC_WIDTH = 32
) (
  input logic                  Clk,
  input logic                  Reset,
  fetch_pc_sequencer_if.slave  bus
);

`ifdef FETCH_DELAY_SLOT_EN
  localparam logic FLUSH_ON_REDIRECT = 1'b0;
`else
  localparam logic FLUSH_ON_REDIRECT = 1'b1;
`endif

  typedef enum logic [1:0] {INIT, RUN, PENDING, HALT} state_t;

  state_t              state, stateNext;
  logic [PC_WIDTH-1:0] pc, pcNext;
  logic [PC_WIDTH-1:0] pcD, pcDNext;
  logic [PC_WIDTH-1:0] pendingTarget, pendingNext;
  logic                flushQ, flushNext;
  logic                addrErrQ, addrErrNext;

  logic [PC_WIDTH-1:0] pcDPlus4;
  logic [PC_WIDTH-1:0] redirTarget;
  logic                redirValid;
  logic                redirMisaligned;

  // Pick the highest-priority redirect and form its target from the decode PC.
  always_comb begin
    pcDPlus4    = pcD + PC_WIDTH'(4);
    redirValid  = bus.JumpRegValid | bus.JumpValid | bus.BranchTaken;
    redirTarget = pcDPlus4 + bus.BranchOffset;
    if (bus.JumpRegValid) begin
      redirTarget = bus.RegTarget;
    end else if (bus.JumpValid) begin
      redirTarget = {pcDPlus4[31:28], bus.Jump};
    end
    redirMisaligned = redirValid && (redirTarget[1:0] != 2'b00);
  end

  // Next-state and next-PC decisions; a misaligned target halts even while stalled.
  always_comb begin
    stateNext   = state;
    pcNext      = pc;
    pcDNext     = pcD;
    pendingNext = pendingTarget;
    flushNext   = 1'b0;
    addrErrNext = 1'b0;
    case (state)
      INIT: begin
        stateNext = RUN;
      end
      RUN: begin
        if (redirMisaligned) begin
          stateNext   = HALT;
          addrErrNext = 1'b1;
        end else if (bus.Stall) begin
          if (redirValid) begin
            pendingNext = redirTarget;
            stateNext   = PENDING;
          end
        end else begin
          pcDNext = pc;
          if (redirValid) begin
            pcNext    = redirTarget;
            flushNext = FLUSH_ON_REDIRECT;
          end else begin
            pcNext = pc + PC_WIDTH'(4);
          end
        end
      end
      PENDING: begin
        if (!bus.Stall) begin
          pcNext      = pendingTarget;
          pcDNext     = pc;
          pendingNext = '0;
          flushNext   = FLUSH_ON_REDIRECT;
          stateNext   = RUN;
        end
      end
      HALT: begin
        stateNext = HALT;
      end
      default: begin
        stateNext = INIT;
      end
    endcase
  end

  // State and PC registers with synchronous reset to the text segment base.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state         <= INIT;
      pc            <= RESET_PC;
      pcD           <= RESET_PC;
      pendingTarget <= '0;
      flushQ        <= 1'b0;
      addrErrQ      <= 1'b0;
    end else begin
      state         <= stateNext;
      pc            <= pcNext;
      pcD           <= pcDNext;
      pendingTarget <= pendingNext;
      flushQ        <= flushNext;
      addrErrQ      <= addrErrNext;
    end
  end

  // Drive the fetch-side outputs; fetch is valid only while sequencing.
  always_comb begin
    bus.PC         = pc;
    bus.PCPlus4    = pc + PC_WIDTH'(4);
    bus.FetchValid = (state == RUN) || (state == PENDING);
    bus.Flush      = flushQ;
    bus.AddrError  = addrErrQ;
  end

endmodule

// File: tb/tb_fetch_pc_sequencer.sv
// Self-checking bench for fetch_pc_sequencer. Each scenario queues per-cycle
// stimulus with its expected result; the expectation is pushed to the
// scoreboard as the stimulus is driven and popped after the clock edge.
module tb_fetch_pc_sequencer;

`ifdef FETCH_DELAY_SLOT_EN
  localparam logic EXP_FLUSH = 1'b0;
`else
  localparam logic EXP_FLUSH = 1'b1;
`endif

  typedef struct {
    logic        rst;
    logic        stall;
    logic        jv;
    logic [27:0] jump;
    logic        jrv;
    logic [31:0] rt;
    logic        bt;
    logic [31:0] bo;
  } stim_t;

  typedef struct {
    logic [31:0] pc;
    logic        fv;
    logic        fl;
    logic        ae;
  } exp_t;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  int   cmpCnt = 0;
  int   errCnt = 0;
  exp_t scoreboard[$];

  fetch_pc_sequencer_if bus();

  fetch_pc_sequencer dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  function automatic stim_t mk(logic rst, logic st, logic jv, logic [27:0] j,
                               logic jrv, logic [31:0] rt, logic bt, logic [31:0] bo);
    stim_t s;
    s.rst = rst; s.stall = st; s.jv = jv; s.jump = j;
    s.jrv = jrv; s.rt = rt; s.bt = bt; s.bo = bo;
    return s;
  endfunction

  function automatic stim_t idle();
    return mk(1'b0, 1'b0, 1'b0, 28'h0, 1'b0, 32'h0, 1'b0, 32'h0);
  endfunction

  function automatic exp_t ex(logic [31:0] pc, logic fv, logic fl, logic ae);
    exp_t e;
    e.pc = pc; e.fv = fv; e.fl = fl; e.ae = ae;
    return e;
  endfunction

  task automatic applyStimulus(input stim_t s);
    Reset            = s.rst;
    bus.Stall        = s.stall;
    bus.JumpValid    = s.jv;
    bus.Jump         = s.jump;
    bus.JumpRegValid = s.jrv;
    bus.RegTarget    = s.rt;
    bus.BranchTaken  = s.bt;
    bus.BranchOffset = s.bo;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Reset and step through INIT; leaves the DUT in RUN with PC = 0x00400000.
  task automatic resetDut();
    applyStimulus(mk(1'b1, 1'b0, 1'b0, 28'h0, 1'b0, 32'h0, 1'b0, 32'h0));
    tick();
    applyStimulus(idle());
    tick();
  endtask

  task automatic test_reset();
    stim_t sq[$];
    exp_t  eq[$];
    exp_t  e;
    sq.push_back(mk(1'b1, 1'b0, 1'b0, 28'h0, 1'b0, 32'h0, 1'b0, 32'h0)); eq.push_back(ex(32'h0040_0000, 1'b0, 1'b0, 1'b0));
    sq.push_back(mk(1'b0, 1'b0, 1'b0, 28'h0, 1'b1, 32'h1234_0000, 1'b0, 32'h0)); eq.push_back(ex(32'h0040_0000, 1'b1, 1'b0, 1'b0));
    sq.push_back(idle()); eq.push_back(ex(32'h0040_0004, 1'b1, 1'b0, 1'b0));
    sq.push_back(idle()); eq.push_back(ex(32'h0040_0008, 1'b1, 1'b0, 1'b0));
    for (int i = 0; i < sq.size(); i++) begin
      applyStimulus(sq[i]);
      scoreboard.push_back(eq[i]);
      tick();
      e = scoreboard.pop_front();
      cmpCnt += 5;
      if (bus.PC !== e.pc) begin errCnt++; $display("[TB] FAIL reset.pc row %0d: got %h want %h", i, bus.PC, e.pc); end
      if (bus.PCPlus4 !== e.pc + 32'd4) begin errCnt++; $display("[TB] FAIL reset.pcplus4 row %0d: got %h want %h", i, bus.PCPlus4, e.pc + 32'd4); end
      if (bus.FetchValid !== e.fv) begin errCnt++; $display("[TB] FAIL reset.fetchvalid row %0d: got %b want %b", i, bus.FetchValid, e.fv); end
      if (bus.Flush !== e.fl) begin errCnt++; $display("[TB] FAIL reset.flush row %0d: got %b want %b", i, bus.Flush, e.fl); end
      if (bus.AddrError !== e.ae) begin errCnt++; $display("[TB] FAIL reset.addrerror row %0d: got %b want %b", i, bus.AddrError, e.ae); end
    end
  endtask

  task automatic test_jump();
    stim_t sq[$];
    exp_t  eq[$];
    exp_t  e;
    resetDut();
    for (int k = 1; k <= 5; k++) begin
      sq.push_back(idle()); eq.push_back(ex(32'h0040_0000 + 32'(4 * k), 1'b1, 1'b0, 1'b0));
    end
    sq.push_back(mk(1'b0, 1'b0, 1'b1, 28'h100_0040, 1'b0, 32'h0, 1'b0, 32'h0)); eq.push_back(ex(32'h0100_0040, 1'b1, EXP_FLUSH, 1'b0));
    sq.push_back(idle()); eq.push_back(ex(32'h0100_0044, 1'b1, 1'b0, 1'b0));
    for (int i = 0; i < sq.size(); i++) begin
      applyStimulus(sq[i]);
      scoreboard.push_back(eq[i]);
      tick();
      e = scoreboard.pop_front();
      cmpCnt += 5;
      if (bus.PC !== e.pc) begin errCnt++; $display("[TB] FAIL jump.pc row %0d: got %h want %h", i, bus.PC, e.pc); end
      if (bus.PCPlus4 !== e.pc + 32'd4) begin errCnt++; $display("[TB] FAIL jump.pcplus4 row %0d: got %h want %h", i, bus.PCPlus4, e.pc + 32'd4); end
      if (bus.FetchValid !== e.fv) begin errCnt++; $display("[TB] FAIL jump.fetchvalid row %0d: got %b want %b", i, bus.FetchValid, e.fv); end
      if (bus.Flush !== e.fl) begin errCnt++; $display("[TB] FAIL jump.flush row %0d: got %b want %b", i, bus.Flush, e.fl); end
      if (bus.AddrError !== e.ae) begin errCnt++; $display("[TB] FAIL jump.addrerror row %0d: got %b want %b", i, bus.AddrError, e.ae); end
    end
  endtask

  task automatic test_branch_priority();
    stim_t sq[$];
    exp_t  eq[$];
    exp_t  e;
    for (int pass = 0; pass < 2; pass++) begin
      sq.delete();
      eq.delete();
      resetDut();
      for (int k = 1; k <= 9; k++) begin
        sq.push_back(idle()); eq.push_back(ex(32'h0040_0000 + 32'(4 * k), 1'b1, 1'b0, 1'b0));
      end
      if (pass == 0) begin
        sq.push_back(mk(1'b0, 1'b0, 1'b0, 28'h0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFF0)); eq.push_back(ex(32'h0040_0014, 1'b1, EXP_FLUSH, 1'b0));
        sq.push_back(idle()); eq.push_back(ex(32'h0040_0018, 1'b1, 1'b0, 1'b0));
      end else begin
        sq.push_back(mk(1'b0, 1'b0, 1'b1, 28'h000_3000, 1'b1, 32'h0040_1000, 1'b1, 32'hFFFF_FFF0)); eq.push_back(ex(32'h0040_1000, 1'b1, EXP_FLUSH, 1'b0));
        sq.push_back(idle()); eq.push_back(ex(32'h0040_1004, 1'b1, 1'b0, 1'b0));
        sq.push_back(mk(1'b0, 1'b0, 1'b1, 28'h000_2000, 1'b0, 32'h0, 1'b1, 32'h0000_0100)); eq.push_back(ex(32'h0000_2000, 1'b1, EXP_FLUSH, 1'b0));
      end
      for (int i = 0; i < sq.size(); i++) begin
        applyStimulus(sq[i]);
        scoreboard.push_back(eq[i]);
        tick();
        e = scoreboard.pop_front();
        cmpCnt += 5;
        if (bus.PC !== e.pc) begin errCnt++; $display("[TB] FAIL branch.pc pass %0d row %0d: got %h want %h", pass, i, bus.PC, e.pc); end
        if (bus.PCPlus4 !== e.pc + 32'd4) begin errCnt++; $display("[TB] FAIL branch.pcplus4 pass %0d row %0d: got %h want %h", pass, i, bus.PCPlus4, e.pc + 32'd4); end
        if (bus.FetchValid !== e.fv) begin errCnt++; $display("[TB] FAIL branch.fetchvalid pass %0d row %0d: got %b want %b", pass, i, bus.FetchValid, e.fv); end
        if (bus.Flush !== e.fl) begin errCnt++; $display("[TB] FAIL branch.flush pass %0d row %0d: got %b want %b", pass, i, bus.Flush, e.fl); end
        if (bus.AddrError !== e.ae) begin errCnt++; $display("[TB] FAIL branch.addrerror pass %0d row %0d: got %b want %b", pass, i, bus.AddrError, e.ae); end
      end
    end
  endtask

  task automatic test_stall_pending();
    stim_t sq[$];
    exp_t  eq[$];
    exp_t  e;
    resetDut();
    sq.push_back(idle()); eq.push_back(ex(32'h0040_0004, 1'b1, 1'b0, 1'b0));
    sq.push_back(mk(1'b0, 1'b1, 1'b1, 28'h200_0000, 1'b0, 32'h0, 1'b0, 32'h0)); eq.push_back(ex(32'h0040_0004, 1'b1, 1'b0, 1'b0));
    sq.push_back(mk(1'b0, 1'b1, 1'b0, 28'h0, 1'b0, 32'h0, 1'b1, 32'h0000_0100)); eq.push_back(ex(32'h0040_0004, 1'b1, 1'b0, 1'b0));
    sq.push_back(mk(1'b0, 1'b1, 1'b0, 28'h0, 1'b0, 32'h0, 1'b0, 32'h0)); eq.push_back(ex(32'h0040_0004, 1'b1, 1'b0, 1'b0));
    sq.push_back(mk(1'b0, 1'b0, 1'b0, 28'h0, 1'b0, 32'h0, 1'b1, 32'h0000_0100)); eq.push_back(ex(32'h0200_0000, 1'b1, EXP_FLUSH, 1'b0));
    sq.push_back(idle()); eq.push_back(ex(32'h0200_0004, 1'b1, 1'b0, 1'b0));
    for (int i = 0; i < sq.size(); i++) begin
      applyStimulus(sq[i]);
      scoreboard.push_back(eq[i]);
      tick();
      e = scoreboard.pop_front();
      cmpCnt += 5;
      if (bus.PC !== e.pc) begin errCnt++; $display("[TB] FAIL stall.pc row %0d: got %h want %h", i, bus.PC, e.pc); end
      if (bus.PCPlus4 !== e.pc + 32'd4) begin errCnt++; $display("[TB] FAIL stall.pcplus4 row %0d: got %h want %h", i, bus.PCPlus4, e.pc + 32'd4); end
      if (bus.FetchValid !== e.fv) begin errCnt++; $display("[TB] FAIL stall.fetchvalid row %0d: got %b want %b", i, bus.FetchValid, e.fv); end
      if (bus.Flush !== e.fl) begin errCnt++; $display("[TB] FAIL stall.flush row %0d: got %b want %b", i, bus.Flush, e.fl); end
      if (bus.AddrError !== e.ae) begin errCnt++; $display("[TB] FAIL stall.addrerror row %0d: got %b want %b", i, bus.AddrError, e.ae); end
    end
  endtask

  task automatic test_misaligned();
    stim_t sq[$];
    exp_t  eq[$];
    exp_t  e;
    resetDut();
    sq.push_back(idle()); eq.push_back(ex(32'h0040_0004, 1'b1, 1'b0, 1'b0));
    sq.push_back(mk(1'b0, 1'b0, 1'b0, 28'h0, 1'b1, 32'h0040_0102, 1'b0, 32'h0)); eq.push_back(ex(32'h0040_0004, 1'b0, 1'b0, 1'b1));
    sq.push_back(idle()); eq.push_back(ex(32'h0040_0004, 1'b0, 1'b0, 1'b0));
    sq.push_back(mk(1'b0, 1'b0, 1'b1, 28'h100_0000, 1'b0, 32'h0, 1'b0, 32'h0)); eq.push_back(ex(32'h0040_0004, 1'b0, 1'b0, 1'b0));
    sq.push_back(mk(1'b1, 1'b0, 1'b0, 28'h0, 1'b0, 32'h0, 1'b0, 32'h0)); eq.push_back(ex(32'h0040_0000, 1'b0, 1'b0, 1'b0));
    sq.push_back(idle()); eq.push_back(ex(32'h0040_0000, 1'b1, 1'b0, 1'b0));
    for (int i = 0; i < sq.size(); i++) begin
      applyStimulus(sq[i]);
      scoreboard.push_back(eq[i]);
      tick();
      e = scoreboard.pop_front();
      cmpCnt += 5;
      if (bus.PC !== e.pc) begin errCnt++; $display("[TB] FAIL misaligned.pc row %0d: got %h want %h", i, bus.PC, e.pc); end
      if (bus.PCPlus4 !== e.pc + 32'd4) begin errCnt++; $display("[TB] FAIL misaligned.pcplus4 row %0d: got %h want %h", i, bus.PCPlus4, e.pc + 32'd4); end
      if (bus.FetchValid !== e.fv) begin errCnt++; $display("[TB] FAIL misaligned.fetchvalid row %0d: got %b want %b", i, bus.FetchValid, e.fv); end
      if (bus.Flush !== e.fl) begin errCnt++; $display("[TB] FAIL misaligned.flush row %0d: got %b want %b", i, bus.Flush, e.fl); end
      if (bus.AddrError !== e.ae) begin errCnt++; $display("[TB] FAIL misaligned.addrerror row %0d: got %b want %b", i, bus.AddrError, e.ae); end
    end
  endtask

  task automatic test_wrap();
    stim_t sq[$];
    exp_t  eq[$];
    exp_t  e;
    resetDut();
    sq.push_back(idle()); eq.push_back(ex(32'h0040_0004, 1'b1, 1'b0, 1'b0));
    sq.push_back(mk(1'b0, 1'b0, 1'b0, 28'h0, 1'b1, 32'hFFFF_FFF8, 1'b0, 32'h0)); eq.push_back(ex(32'hFFFF_FFF8, 1'b1, EXP_FLUSH, 1'b0));
    sq.push_back(idle()); eq.push_back(ex(32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0));
    sq.push_back(idle()); eq.push_back(ex(32'h0000_0000, 1'b1, 1'b0, 1'b0));
    sq.push_back(idle()); eq.push_back(ex(32'h0000_0004, 1'b1, 1'b0, 1'b0));
    for (int i = 0; i < sq.size(); i++) begin
      applyStimulus(sq[i]);
      scoreboard.push_back(eq[i]);
      tick();
      e = scoreboard.pop_front();
      cmpCnt += 5;
      if (bus.PC !== e.pc) begin errCnt++; $display("[TB] FAIL wrap.pc row %0d: got %h want %h", i, bus.PC, e.pc); end
      if (bus.PCPlus4 !== e.pc + 32'd4) begin errCnt++; $display("[TB] FAIL wrap.pcplus4 row %0d: got %h want %h", i, bus.PCPlus4, e.pc + 32'd4); end
      if (bus.FetchValid !== e.fv) begin errCnt++; $display("[TB] FAIL wrap.fetchvalid row %0d: got %b want %b", i, bus.FetchValid, e.fv); end
      if (bus.Flush !== e.fl) begin errCnt++; $display("[TB] FAIL wrap.flush row %0d: got %b want %b", i, bus.Flush, e.fl); end
      if (bus.AddrError !== e.ae) begin errCnt++; $display("[TB] FAIL wrap.addrerror row %0d: got %b want %b", i, bus.AddrError, e.ae); end
    end
  endtask

  initial begin
    applyStimulus(mk(1'b1, 1'b0, 1'b0, 28'h0, 1'b0, 32'h0, 1'b0, 32'h0));
    test_reset();
    test_jump();
    test_branch_priority();
    test_stall_pending();
    test_misaligned();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCnt, errCnt);
    $finish;
  end

endmodule
